// File: rtl/sdram_req_sched_pkg.sv
// Shared definitions for the SDRAM request scheduler and the SDRAM engine.
//  - state_t        : scheduler FSM encodings
//  - ADDR_W_DEF     : engine byte-address width
//  - RFSH_PERIOD_DEF: sdClk cycles between refresh requests (15.6 us at 25 MHz)
//  - *_MSB / *_LSB  : bank/row/col field positions inside the engine address
//  - acc_addr_of()  : packs a CPU byte address into the engine address layout
package sdram_req_sched_pkg;

    localparam int ADDR_W_DEF      = 25;
    localparam int RFSH_PERIOD_DEF = 390;

    localparam int ROW_MSB  = 24;
    localparam int ROW_LSB  = 13;
    localparam int BANK_MSB = 12;
    localparam int BANK_LSB = 11;
    localparam int COL_MSB  = 10;
    localparam int COL_LSB  = 2;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_WAIT = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    // Word-aligned engine address; the byte offset bits are forced to zero
    // because every access is one full 32-bit word.
    function automatic logic [ADDR_W_DEF-1:0] acc_addr_of(input logic [ROW_MSB:COL_LSB] a);
        return {a[ROW_MSB:ROW_LSB], a[BANK_MSB:BANK_LSB], a[COL_MSB:COL_LSB], 2'b00};
    endfunction

endpackage

// File: rtl/sdram_req_sched_if.sv
// Bundle of the CPU-side and engine-side signals of the request scheduler.
//  - slave : the scheduler (consumes CPU requests and engine status)
//  - master: the environment (CPU plus SDRAM engine)
//
// Handshake semantics:
//  - A CPU request (cpuRdEn or cpuWrEn) is taken only on a cycle where
//    cpuBusy=0; while cpuBusy=1 the enables are ignored. cpuRdValid is a
//    one-cycle strobe with no back-pressure.
//  - accReq is a level held by the scheduler until the engine answers by
//    dropping engIdle; the engine reports progress with the engWriting,
//    engRdDataRdy and engRfshed strobes, and rfshReq is held until engRfshed.
interface sdram_req_sched_if
    import sdram_req_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              cpuRdEn;
    logic              cpuWrEn;
    logic [31:0]       cpuAddr;
    logic [31:0]       cpuWrData;
    logic [3:0]        cpuByteEn;
    logic              cpuBusy;
    logic [31:0]       cpuRdData;
    logic              cpuRdValid;

    logic              engIdle;
    logic              engRdDataRdy;
    logic              engWriting;
    logic              engRfshed;
    logic [31:0]       engRdData;

    logic              accReq;
    logic              accIsWrite;
    logic [ADDR_W-1:0] accAddr;
    logic              accBurstTerm;
    logic [3:0]        sdDqm_c;
    logic [31:0]       engWrData;
    logic              rfshReq;

    modport slave (
        input  cpuRdEn, cpuWrEn, cpuAddr, cpuWrData, cpuByteEn,
        input  engIdle, engRdDataRdy, engWriting, engRfshed, engRdData,
        output cpuBusy, cpuRdData, cpuRdValid,
        output accReq, accIsWrite, accAddr, accBurstTerm, sdDqm_c, engWrData, rfshReq
    );

    modport master (
        output cpuRdEn, cpuWrEn, cpuAddr, cpuWrData, cpuByteEn,
        output engIdle, engRdDataRdy, engWriting, engRfshed, engRdData,
        input  cpuBusy, cpuRdData, cpuRdValid,
        input  accReq, accIsWrite, accAddr, accBurstTerm, sdDqm_c, engWrData, rfshReq
    );

endinterface

// File: rtl/sdram_rfsh_timer.sv
// Periodic auto-refresh request generator.
//  - sdClk    : controller clock
//  - rstN     : asynchronous reset, active-low
//  - rfsh_done: engine strobe, auto-refresh issued
//  - rfsh_req : refresh request, held until rfsh_done
// The down-counter free-runs and reloads at zero regardless of whether the
// previous request was serviced, so the refresh cadence never drifts.
module sdram_rfsh_timer #(
    parameter int RFSH_PERIOD = 390
) (
    input  logic sdClk,
    input  logic rstN,
    input  logic rfsh_done,
    output logic rfsh_req
);

    localparam int CNT_W = $clog2(RFSH_PERIOD);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(RFSH_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             expire;

    assign expire = (cnt_q == '0);

    always_ff @(posedge sdClk or negedge rstN) begin
        if (!rstN) begin
            cnt_q    <= RELOAD;
            rfsh_req <= 1'b0;
        end else begin
            if (expire) begin
                cnt_q <= RELOAD;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // A new expiry wins over a same-cycle completion: that is a fresh
            // refresh interval which still needs its own refresh.
            if (expire) begin
                rfsh_req <= 1'b1;
            end else if (rfsh_done) begin
                rfsh_req <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_req_sched.sv
// Upstream front end of the SDRAM controller engine.
//  - sdClk    : controller clock
//  - rstN     : asynchronous reset, active-low (shared with the engine)
//  - bus      : CPU request/response and engine access signals (slave side)
//  - dbg_state: current FSM state
// Accepts one single-word load/store at a time, latches it, waits for the
// engine to be idle with no refresh pending, starts the access, terminates
// the burst after the first word and returns load data to the CPU.
module sdram_req_sched
    import sdram_req_sched_pkg::*;
#(
    parameter int RFSH_PERIOD = RFSH_PERIOD_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic                sdClk,
    input  logic                rstN,
    sdram_req_sched_if.slave    bus,
    output state_t              dbg_state
);

    state_t            state_q;
    state_t            state_d;

    logic              busy_q;
    logic              is_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wr_data_q;
    logic [3:0]        dqm_q;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;
    logic              burst_term_q;
    logic              rfsh_req;
    logic              take_req;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.cpuAddr[31:ADDR_W_DEF], bus.cpuAddr[COL_LSB-1:0]};

    sdram_rfsh_timer #(
        .RFSH_PERIOD (RFSH_PERIOD)
    ) u_rfsh_timer (
        .sdClk     (sdClk),
        .rstN      (rstN),
        .rfsh_done (bus.engRfshed),
        .rfsh_req  (rfsh_req)
    );

    // A request is latched only in S_IDLE while not already holding one.
    assign take_req = (state_q == S_IDLE) && !busy_q && (bus.cpuRdEn || bus.cpuWrEn);

    always_ff @(posedge sdClk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // Refresh has priority: a latched request waits here while rfshReq=1.
            S_IDLE: begin
                if (busy_q && bus.engIdle && !rfsh_req) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!bus.engIdle) begin
                    state_d = is_write_q ? S_WR_WAIT : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (bus.engRdDataRdy) begin
                    state_d = S_DRAIN;
                end
            end
            S_WR_WAIT: begin
                if (bus.engWriting) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.engIdle) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch and response registers. The latched access fields only change
    // on take_req, so they stay stable from S_ISSUE through S_DRAIN.
    always_ff @(posedge sdClk or negedge rstN) begin
        if (!rstN) begin
            busy_q       <= 1'b0;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wr_data_q    <= '0;
            dqm_q        <= 4'hF;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            burst_term_q <= 1'b0;
        end else begin
            rd_valid_q   <= 1'b0;
            burst_term_q <= 1'b0;

            if (take_req) begin
                busy_q     <= 1'b1;
                // Write wins when both enables are high.
                is_write_q <= bus.cpuWrEn;
                addr_q     <= ADDR_W'(acc_addr_of(bus.cpuAddr[ROW_MSB:COL_LSB]));
                wr_data_q  <= bus.cpuWrData;
                dqm_q      <= bus.cpuWrEn ? ~bus.cpuByteEn : 4'b0000;
            end

            // Only the first engRdDataRdy of the access is captured; the FSM
            // has left S_RD_WAIT by the next cycle.
            if ((state_q == S_RD_WAIT) && bus.engRdDataRdy) begin
                rd_data_q    <= bus.engRdData;
                rd_valid_q   <= 1'b1;
                burst_term_q <= 1'b1;
            end

            if ((state_q == S_WR_WAIT) && bus.engWriting) begin
                burst_term_q <= 1'b1;
            end

            if ((state_q == S_DRAIN) && bus.engIdle) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.cpuBusy      = busy_q;
    assign bus.cpuRdData    = rd_data_q;
    assign bus.cpuRdValid   = rd_valid_q;
    assign bus.accReq       = (state_q == S_ISSUE);
    assign bus.accIsWrite   = is_write_q;
    assign bus.accAddr      = addr_q;
    assign bus.accBurstTerm = burst_term_q;
    assign bus.sdDqm_c      = dqm_q;
    assign bus.engWrData    = wr_data_q;
    assign bus.rfshReq      = rfsh_req;
    assign dbg_state        = state_q;

endmodule
